// File: rtl/sseg_pkg.sv
// Shared constants for the scanned 7-segment receive path: active-high segment
// patterns (bit0=a .. bit6=g), segment bit indices and the scan FSM state type.
package sseg_pkg;

  localparam int SEG_DP_BIT = 7;
  localparam int SEG_G_BIT  = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h58;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sseg_pat2hex.sv
// Combinational decoder from an active-high 7-segment pattern to a hex nibble,
// flagging the all-off pattern as blank and anything else unknown as illegal.
module sseg_pat2hex
  import sseg_pkg::*;
(
  input  logic [SEG_G_BIT:0] pat,
  output logic [3:0]         nibble,
  output logic               blank,
  output logic               illegal
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (pat)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_rx.sv
// Receiver for a scanned active-low 7-segment display: captures each digit once
// its strobe/segment sample is stable. Define SSEG_SCAN_RX_SYNC_EN for 2-flop input sync.
//
// state | meaning
// IDLE  | no strobe, or more than one strobe active
// TRACK | one strobe active, counting identical samples
// HOLD  | digit captured, waiting for the sample to change
module sseg_scan_rx
  import sseg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   dig_n,
  input  logic              clr,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   illegal,
  output logic              frame_stb,
  output logic              scan_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);

  logic [7:0]      s_seg;
  logic [NDIG-1:0] s_dig;

`ifdef SSEG_SCAN_RX_SYNC_EN
  logic [7:0]      seg_sync1_q, seg_sync2_q;
  logic [NDIG-1:0] dig_sync1_q, dig_sync2_q;

  // Reset to all ones so the sampled bus reads as inactive until real data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync1_q <= '1;
      seg_sync2_q <= '1;
      dig_sync1_q <= '1;
      dig_sync2_q <= '1;
    end else begin
      seg_sync1_q <= seg_n;
      seg_sync2_q <= seg_sync1_q;
      dig_sync1_q <= dig_n;
      dig_sync2_q <= dig_sync1_q;
    end
  end

  assign s_seg = ~seg_sync2_q;
  assign s_dig = ~dig_sync2_q;
`else
  assign s_seg = ~seg_n;
  assign s_dig = ~dig_n;
`endif

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        prev_seg_q, prev_seg_d;
  logic [NDIG-1:0]   prev_dig_q, prev_dig_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   illegal_q, illegal_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              frame_stb_q, frame_stb_d;
  logic              scan_err_q, scan_err_d;

  logic [3:0] dec_nibble;
  logic       dec_blank, dec_illegal;

  sseg_pat2hex u_pat2hex (
    .pat     (s_seg[SEG_G_BIT:0]),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  logic dig_any, dig_onehot, dig_multi, same;

  assign dig_any    = |s_dig;
  assign dig_onehot = dig_any && ((s_dig & (s_dig - NDIG'(1))) == '0);
  assign dig_multi  = dig_any && !dig_onehot;
  assign same       = (s_seg == prev_seg_q) && (s_dig == prev_dig_q);

  always_comb begin
    logic [7:0]      cnt_inc;
    logic [NDIG-1:0] seen_set;

    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_seg_d  = s_seg;
    prev_dig_d  = s_dig;
    digits_d    = digits_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    illegal_d   = illegal_q;
    seen_d      = seen_q;
    frame_stb_d = 1'b0;
    scan_err_d  = scan_err_q;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    seen_set    = seen_q | s_dig;

    if (clr) begin
      state_d   = IDLE;
      cnt_d     = 8'd0;
      digits_d  = '0;
      dp_d      = '0;
      blank_d   = '1;
      illegal_d = '0;
      seen_d    = '0;
      scan_err_d = 1'b0;
    end else if (!dig_onehot) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      if (dig_multi) scan_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
        TRACK: begin
          if (!same) begin
            cnt_d = 8'd1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = HOLD;
              for (int i = 0; i < NDIG; i++) begin
                if (s_dig[i]) begin
                  digits_d[4*i +: 4] = dec_nibble;
                  dp_d[i]            = s_seg[SEG_DP_BIT];
                  blank_d[i]         = dec_blank;
                  illegal_d[i]       = dec_illegal;
                end
              end
              // A completed frame restarts the mask empty.
              if (&seen_set) begin
                frame_stb_d = 1'b1;
                seen_d      = '0;
              end else begin
                seen_d = seen_set;
              end
            end
          end
        end
        HOLD: begin
          if (!same) begin
            state_d = TRACK;
            cnt_d   = 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      prev_seg_q  <= '0;
      prev_dig_q  <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      blank_q     <= '1;
      illegal_q   <= '0;
      seen_q      <= '0;
      frame_stb_q <= 1'b0;
      scan_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_seg_q  <= prev_seg_d;
      prev_dig_q  <= prev_dig_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      illegal_q   <= illegal_d;
      seen_q      <= seen_d;
      frame_stb_q <= frame_stb_d;
      scan_err_q  <= scan_err_d;
    end
  end

  assign digits    = digits_q;
  assign dp        = dp_q;
  assign blank     = blank_q;
  assign illegal   = illegal_q;
  assign frame_stb = frame_stb_q;
  assign scan_err  = scan_err_q;

endmodule
